// File: rtl/mux_stream_pkg.sv
// Shared constants for the stream multiplexer: grant mode encodings and
// the transfer counter geometry.
package mux_stream_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or above ptr, wrapping to the
// lowest requester when nothing at or above ptr is asking.
module rr_pick #(
    parameter int unsigned NCH = 4,
    localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt,
    output logic            any
);

    logic found;

    // Masked pass first (index >= ptr), then an unmasked pass for the wrap.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        any   = |req;
        for (int i = 0; i < NCH; i++) begin
            if (!found && req[i] && (SELW'(i) >= ptr)) begin
                gnt   = SELW'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!found && req[i]) begin
                gnt   = SELW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_stream_rr.sv
// N-channel valid/ready stream multiplexer with direct-select and
// round-robin grant modes feeding a single registered output stage.
module mux_stream_rr
    import mux_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     xfer_cnt
);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] rr_gnt;
    logic            rr_any;
    logic [SELW-1:0] gnt;
    logic            grant_vld;
    logic            sel_vld;
    logic            load_en;
    logic            take;

    rr_pick #(.NCH(NCH)) u_pick (
        .req (in_valid),
        .ptr (ptr),
        .gnt (rr_gnt),
        .any (rr_any)
    );

    assign load_en = !out_valid || out_ready;

    // Out-of-range sel matches no channel, so it never grants.
    always_comb begin
        sel_vld = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) begin
                sel_vld = in_valid[k];
            end
        end
    end

    always_comb begin
        gnt       = '0;
        grant_vld = 1'b0;
        if (mode == MODE_RR) begin
            gnt       = rr_gnt;
            grant_vld = rr_any;
        end else begin
            gnt       = sel;
            grant_vld = sel_vld;
        end
    end

    // Ready is one-hot on the granted channel and forced low during reset.
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            in_ready[k] = rst_n && load_en && grant_vld && (gnt == SELW'(k));
        end
    end

    assign take = |(in_valid & in_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load_en) begin
            if (take) begin
                out_data  <= in_data[32'(gnt) * WIDTH +: WIDTH];
                out_ch    <= gnt;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (take && (mode == MODE_RR)) begin
            ptr <= (gnt == SELW'(NCH - 1)) ? '0 : gnt + SELW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready && (xfer_cnt != CNT_MAX)) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule
